// File: rtl/screen_fetch.sv
`default_nettype none
// screen_fetch: reads the CHIP-8 framebuffer byte by byte over the CPU screen-read
// handshake and streams it to the display driver through a small FIFO.
module screen_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_BYTES  = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    output logic       scr_busy,
    output logic       scr_read,
    output logic [7:0] scr_read_idx,
    input  logic [7:0] scr_read_byte,
    input  logic       scr_read_ack,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_first,
    output logic       out_last,
    input  logic       out_ready,
    output logic       overrun
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic [9:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        scr_read  = 1'b0;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    busy_d  = 1'b1;
                    idx_d   = 8'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // The FIFO slot is reserved here so the matching ack can always push.
                if (count_q < FULL_CNT) begin
                    scr_read = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (scr_read_ack) begin
                    push = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (frame_start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    assign pop = (count_q != '0) && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'd0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= {(idx_q == 8'd0), (idx_q == LAST_IDX), scr_read_byte};
        end
    end

    assign scr_busy     = busy_q;
    assign scr_read_idx = idx_q;
    assign overrun      = overrun_q;
    assign out_valid    = (count_q != '0);
    assign {out_first, out_last, out_data} = fifo_q[rd_ptr_q];

endmodule
`default_nettype wire
